// File: rtl/armleocpu_branch_resolve_pkg.sv
// Shared constants for the execute-stage control-transfer path:
// opcode class encodings, branch funct3 values and the resolve FSM states.
package armleocpu_branch_resolve_pkg;

    // Control-transfer class presented on in_op
    localparam logic [1:0] BR_OP_BRANCH = 2'b00;
    localparam logic [1:0] BR_OP_JAL    = 2'b01;
    localparam logic [1:0] BR_OP_JALR   = 2'b10;
    localparam logic [1:0] BR_OP_RSVD   = 2'b11;

    // Conditional branch funct3 encodings (010 and 011 are unassigned)
    localparam logic [2:0] BR_F3_BEQ  = 3'b000;
    localparam logic [2:0] BR_F3_BNE  = 3'b001;
    localparam logic [2:0] BR_F3_BLT  = 3'b100;
    localparam logic [2:0] BR_F3_BGE  = 3'b101;
    localparam logic [2:0] BR_F3_BLTU = 3'b110;
    localparam logic [2:0] BR_F3_BGEU = 3'b111;

    localparam int unsigned XLEN = 32;

    // Resolve unit state: free, or holding a redirect until fetch takes it
    typedef enum logic {
        BR_STATE_IDLE          = 1'b0,
        BR_STATE_WAIT_REDIRECT = 1'b1
    } br_state_t;

endpackage

// File: rtl/armleocpu_branch_resolve_brcond.sv
// Branch condition evaluator: decides taken/not-taken for a conditional
// branch from funct3 and flags funct3 values that name no comparison.
module armleocpu_brcond
    import armleocpu_branch_resolve_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_illegal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    // Select the comparison named by funct3; unassigned codes never take
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            BR_F3_BEQ:  o_taken = w_eq;
            BR_F3_BNE:  o_taken = !w_eq;
            BR_F3_BLT:  o_taken = w_lt;
            BR_F3_BGE:  o_taken = !w_lt;
            BR_F3_BLTU: o_taken = w_ltu;
            BR_F3_BGEU: o_taken = !w_ltu;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/armleocpu_branch_resolve.sv
// Execute-stage branch resolution: computes the architectural next PC of a
// BRANCH/JAL/JALR, compares it with the path fetch followed, and on a
// mismatch raises a one-cycle flush plus a redirect held until fetch takes it.
module armleocpu_branch_resolve
    import armleocpu_branch_resolve_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pred_pc,

    output logic            res_valid,
    output logic [XLEN-1:0] res_link,
    output logic            res_illegal,
    output logic            res_misaligned,

    output logic            flush,

    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,

    output logic [XLEN-1:0] cnt_branch,
    output logic [XLEN-1:0] cnt_mispredict
);

    br_state_t       r_state;
    br_state_t       w_state_next;

    logic            w_accept;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_cond_taken;
    logic            w_cond_illegal;
    logic            w_illegal;
    logic            w_taken;
    logic            w_misaligned;
    logic            w_mispredict;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target_pc;
    logic [XLEN-1:0] w_next_pc;

    logic            r_res_valid;
    logic [XLEN-1:0] r_res_link;
    logic            r_res_illegal;
    logic            r_res_misaligned;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;
    logic [XLEN-1:0] r_cnt_branch;
    logic [XLEN-1:0] r_cnt_mispredict;

    armleocpu_brcond u_brcond (
        .i_funct3  (in_funct3),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .o_taken   (w_cond_taken),
        .o_illegal (w_cond_illegal)
    );

    // Target, next-PC and exception/mispredict decode for the presented op
    always_comb begin
        w_is_branch  = (in_op == BR_OP_BRANCH);
        w_is_jal     = (in_op == BR_OP_JAL);
        w_is_jalr    = (in_op == BR_OP_JALR);
        w_illegal    = (in_op == BR_OP_RSVD) || (w_is_branch && w_cond_illegal);
        w_taken      = w_is_branch ? w_cond_taken : (w_is_jal || w_is_jalr);
        w_seq_pc     = in_pc + 32'd4;
        w_jalr_sum   = in_rs1 + in_imm;
        w_target_pc  = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
        w_next_pc    = w_taken ? w_target_pc : w_seq_pc;
        // Only a taken target can fault; illegal wins over misaligned
        w_misaligned = !w_illegal && w_taken && (w_target_pc[1:0] != 2'b00);
        w_mispredict = !w_illegal && !w_misaligned && (w_next_pc != in_pred_pc);
    end

    // Next-state and handshake outputs of the redirect FSM
    always_comb begin
        w_state_next   = r_state;
        in_ready       = 1'b0;
        redirect_valid = 1'b0;
        w_accept       = 1'b0;
        case (r_state)
            BR_STATE_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_mispredict)
                    w_state_next = BR_STATE_WAIT_REDIRECT;
            end
            BR_STATE_WAIT_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready)
                    w_state_next = BR_STATE_IDLE;
            end
            default: w_state_next = BR_STATE_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= BR_STATE_IDLE;
        else
            r_state <= w_state_next;
    end

    // Result strobe, flush pulse and captured redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid      <= 1'b0;
            r_res_link       <= '0;
            r_res_illegal    <= 1'b0;
            r_res_misaligned <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_res_valid      <= w_accept;
            r_res_illegal    <= w_accept && w_illegal;
            r_res_misaligned <= w_accept && w_misaligned;
            r_flush          <= w_accept && w_mispredict;
            if (w_accept)
                r_res_link <= w_seq_pc;
            // Captured only when entering WAIT_REDIRECT, so it stays put while held
            if (w_accept && w_mispredict)
                r_redirect_pc <= w_next_pc;
        end
    end

    // Wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_branch     <= '0;
            r_cnt_mispredict <= '0;
        end else begin
            if (w_accept && w_is_branch)
                r_cnt_branch <= r_cnt_branch + 32'd1;
            if (w_accept && w_mispredict)
                r_cnt_mispredict <= r_cnt_mispredict + 32'd1;
        end
    end

    assign res_valid      = r_res_valid;
    assign res_link       = r_res_link;
    assign res_illegal    = r_res_illegal;
    assign res_misaligned = r_res_misaligned;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign cnt_branch     = r_cnt_branch;
    assign cnt_mispredict = r_cnt_mispredict;

endmodule
